// File: rtl/retry_pkg.sv
// Shared types and helpers for the remote retry state machine (rrsm).
package retry_pkg;

  localparam int SEQ_W_DEFAULT       = 8;
  localparam int NUM_RETRY_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    REMOTE_NORMAL = 2'd0,
    LLRACK        = 2'd1,
    REPLAY        = 2'd2
  } rrsm_state_e;

  // Modular distance a - b; callers truncate to their pointer width, which
  // keeps the result correct modulo 2^width for any width up to 32.
  function automatic logic [31:0] seq_dist(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/rrsm_if.sv
// Unpacker / packer / retry-buffer signal bundle seen by the remote retry state machine.
interface rrsm_if #(
  parameter int SEQ_W       = 8,
  parameter int NUM_RETRY_W = 5
);
  logic                   unpacker_retry_req_valid;
  logic [SEQ_W-1:0]       unpacker_retry_req_eseq;
  logic [NUM_RETRY_W-1:0] unpacker_retry_req_num_retry;
  logic [SEQ_W-1:0]       retry_buf_wr_ptr;
  logic [SEQ_W-1:0]       retry_buf_oldest_seq;
  logic                   packer_ack_ready;
  logic                   packer_replay_ready;
  logic                   phy_reinit;
  logic                   retry_send_ack_seq;
  logic [NUM_RETRY_W-1:0] retry_ack_num_retry;
  logic                   retry_ack_empty;
  logic [SEQ_W-1:0]       retry_ack_wr_ptr;
  logic                   retry_replay_valid;
  logic [SEQ_W-1:0]       retry_replay_ptr;
  logic                   retry_replay_active;
  logic                   retry_remote_err;

  modport slave (
    input  unpacker_retry_req_valid, unpacker_retry_req_eseq, unpacker_retry_req_num_retry,
           retry_buf_wr_ptr, retry_buf_oldest_seq, packer_ack_ready, packer_replay_ready,
           phy_reinit,
    output retry_send_ack_seq, retry_ack_num_retry, retry_ack_empty, retry_ack_wr_ptr,
           retry_replay_valid, retry_replay_ptr, retry_replay_active, retry_remote_err
  );

  modport master (
    output unpacker_retry_req_valid, unpacker_retry_req_eseq, unpacker_retry_req_num_retry,
           retry_buf_wr_ptr, retry_buf_oldest_seq, packer_ack_ready, packer_replay_ready,
           phy_reinit,
    input  retry_send_ack_seq, retry_ack_num_retry, retry_ack_empty, retry_ack_wr_ptr,
           retry_replay_valid, retry_replay_ptr, retry_replay_active, retry_remote_err
  );
endinterface

// File: rtl/rrsm_replay_seq.sv
// Replay pointer / remaining-flit counter with load, advance and clear.
module rrsm_replay_seq #(
  parameter int SEQ_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [SEQ_W-1:0] load_ptr_i,
  input  logic [SEQ_W-1:0] load_rem_i,
  input  logic             advance_i,
  input  logic             clear_i,
  output logic [SEQ_W-1:0] ptr_o,
  output logic             last_o
);
  logic [SEQ_W-1:0] ptr_q, ptr_d;
  logic [SEQ_W-1:0] rem_q, rem_d;

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (clear_i) begin
      ptr_d = '0;
      rem_d = '0;
    end else if (load_i) begin
      ptr_d = load_ptr_i;
      rem_d = load_rem_i;
    end else if (advance_i) begin
      ptr_d = ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      rem_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rem_q <= rem_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign last_o = (rem_q == SEQ_W'(1));
endmodule

// File: rtl/rrsm.sv
// Remote retry state machine: answers RETRY.Req with RETRY.Ack, then replays from the retry buffer.
// Optional saturating Ack/flit counters are built when RRSM_REPLAY_STATS_EN is defined.
module rrsm
  import retry_pkg::*;
#(
  parameter int SEQ_W       = SEQ_W_DEFAULT,
  parameter int NUM_RETRY_W = NUM_RETRY_W_DEFAULT
) (
  input  logic  i_clk,
  input  logic  i_rst,
  rrsm_if.slave bus
`ifdef RRSM_REPLAY_STATS_EN
  ,
  output logic [15:0] retry_ack_count,
  output logic [15:0] retry_replay_flit_count
`endif
);
  rrsm_state_e            state_q, state_d;
  logic [NUM_RETRY_W-1:0] num_retry_q;
  logic [SEQ_W-1:0]       wr_ptr_q;
  logic                   empty_q;
  logic                   err_q;

  logic [SEQ_W-1:0] cnt, win, load_rem, ptr;
  logic             req_ok, load, advance, clear, last;

  assign cnt      = SEQ_W'(seq_dist(32'(bus.retry_buf_wr_ptr), 32'(bus.unpacker_retry_req_eseq)));
  assign win      = SEQ_W'(seq_dist(32'(bus.retry_buf_wr_ptr), 32'(bus.retry_buf_oldest_seq)));
  assign req_ok   = (cnt <= win);
  assign load_rem = req_ok ? cnt : '0;

  // phy_reinit overrides everything, including a request arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    clear   = 1'b0;
    if (bus.phy_reinit) begin
      state_d = REMOTE_NORMAL;
      clear   = 1'b1;
    end else begin
      case (state_q)
        REMOTE_NORMAL: begin
          if (bus.unpacker_retry_req_valid) begin
            load    = 1'b1;
            state_d = LLRACK;
          end
        end
        LLRACK: begin
          if (bus.unpacker_retry_req_valid) begin
            load    = 1'b1;
            state_d = LLRACK;
          end else if (bus.packer_ack_ready) begin
            state_d = empty_q ? REMOTE_NORMAL : REPLAY;
          end
        end
        REPLAY: begin
          if (bus.unpacker_retry_req_valid) begin
            load    = 1'b1;
            state_d = LLRACK;
          end else if (bus.packer_replay_ready) begin
            advance = 1'b1;
            if (last) state_d = REMOTE_NORMAL;
          end
        end
        default: begin
          state_d = REMOTE_NORMAL;
          clear   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= REMOTE_NORMAL;
      num_retry_q <= '0;
      wr_ptr_q    <= '0;
      empty_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= load && !req_ok;
      if (clear) begin
        num_retry_q <= '0;
        wr_ptr_q    <= '0;
        empty_q     <= 1'b0;
      end else if (load) begin
        num_retry_q <= bus.unpacker_retry_req_num_retry;
        wr_ptr_q    <= bus.retry_buf_wr_ptr;
        empty_q     <= (load_rem == '0);
      end
    end
  end

  rrsm_replay_seq #(.SEQ_W(SEQ_W)) u_replay_seq (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .load_i     (load),
    .load_ptr_i (bus.unpacker_retry_req_eseq),
    .load_rem_i (load_rem),
    .advance_i  (advance),
    .clear_i    (clear),
    .ptr_o      (ptr),
    .last_o     (last)
  );

  // Ack fields and replay pointer are only presented in the state that owns them.
  assign bus.retry_send_ack_seq  = (state_q == LLRACK);
  assign bus.retry_ack_num_retry = (state_q == LLRACK) ? num_retry_q : '0;
  assign bus.retry_ack_empty     = (state_q == LLRACK) ? empty_q : 1'b0;
  assign bus.retry_ack_wr_ptr    = (state_q == LLRACK) ? wr_ptr_q : '0;
  assign bus.retry_replay_valid  = (state_q == REPLAY);
  assign bus.retry_replay_ptr    = (state_q == REPLAY) ? ptr : '0;
  assign bus.retry_replay_active = (state_q != REMOTE_NORMAL);
  assign bus.retry_remote_err    = err_q;

`ifdef RRSM_REPLAY_STATS_EN
  logic [15:0] ack_count_q, flit_count_q;
  logic        ack_accept;

  assign ack_accept = (state_q == LLRACK) && bus.packer_ack_ready && !bus.phy_reinit;

  // Statistics survive phy_reinit; only i_rst clears them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_count_q  <= '0;
      flit_count_q <= '0;
    end else begin
      if (ack_accept && ack_count_q != 16'hFFFF) ack_count_q <= ack_count_q + 16'd1;
      if (advance && flit_count_q != 16'hFFFF) flit_count_q <= flit_count_q + 16'd1;
    end
  end

  assign retry_ack_count         = ack_count_q;
  assign retry_replay_flit_count = flit_count_q;
`endif
endmodule

// File: tb/tb_rrsm.sv
// Directed self-checking bench for rrsm: replay, empty, wrap, invalid, re-request and reinit cases.
module tb_rrsm;
  logic clk;
  logic srst;
  int   checks = 0;
  int   errors = 0;

  rrsm_if #(.SEQ_W(8), .NUM_RETRY_W(5)) bus ();

`ifdef RRSM_REPLAY_STATS_EN
  logic [15:0] ack_count, flit_count;
`endif

  rrsm #(.SEQ_W(8), .NUM_RETRY_W(5)) dut (
    .i_clk (clk),
    .i_rst (srst),
    .bus   (bus)
`ifdef RRSM_REPLAY_STATS_EN
    ,
    .retry_ack_count         (ack_count),
    .retry_replay_flit_count (flit_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One line per checked cycle, then every output compared.
  task automatic expect_out(input string tag, input int ack, input int num, input int empty,
                            input int wrp, input int rv, input int ptr, input int act, input int err);
    $display("[%0t] %s: ack=%0d num=%0d empty=%0d wrp=%0d rv=%0d ptr=%0d act=%0d err=%0d", $time,
             tag, bus.retry_send_ack_seq, bus.retry_ack_num_retry, bus.retry_ack_empty,
             bus.retry_ack_wr_ptr, bus.retry_replay_valid, bus.retry_replay_ptr,
             bus.retry_replay_active, bus.retry_remote_err);
    chk({tag, ".ack"},   32'(bus.retry_send_ack_seq),  32'(ack));
    chk({tag, ".num"},   32'(bus.retry_ack_num_retry), 32'(num));
    chk({tag, ".empty"}, 32'(bus.retry_ack_empty),     32'(empty));
    chk({tag, ".wrp"},   32'(bus.retry_ack_wr_ptr),    32'(wrp));
    chk({tag, ".rv"},    32'(bus.retry_replay_valid),  32'(rv));
    chk({tag, ".ptr"},   32'(bus.retry_replay_ptr),    32'(ptr));
    chk({tag, ".act"},   32'(bus.retry_replay_active), 32'(act));
    chk({tag, ".err"},   32'(bus.retry_remote_err),    32'(err));
  endtask

  task automatic idle_inputs();
    bus.unpacker_retry_req_valid     = 1'b0;
    bus.unpacker_retry_req_eseq      = '0;
    bus.unpacker_retry_req_num_retry = '0;
    bus.packer_ack_ready             = 1'b0;
    bus.packer_replay_ready          = 1'b0;
    bus.phy_reinit                   = 1'b0;
  endtask

  task automatic request(input int wrp, input int oldest, input int eseq, input int num);
    bus.retry_buf_wr_ptr             = 8'(wrp);
    bus.retry_buf_oldest_seq         = 8'(oldest);
    bus.unpacker_retry_req_eseq      = 8'(eseq);
    bus.unpacker_retry_req_num_retry = 5'(num);
    bus.unpacker_retry_req_valid     = 1'b1;
  endtask

  initial begin
    idle_inputs();
    bus.retry_buf_wr_ptr     = '0;
    bus.retry_buf_oldest_seq = '0;
    srst = 1'b1;
    tick();
    tick();
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    srst = 1'b0;
    tick();
    expect_out("idle", 0, 0, 0, 0, 0, 0, 0, 0);

    // Basic replay 7,8,9
    request(10, 2, 7, 3);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("basic.ack", 1, 3, 0, 10, 0, 0, 1, 0);
    tick();
    expect_out("basic.ackwait", 1, 3, 0, 10, 0, 0, 1, 0);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("basic.r7", 0, 0, 0, 0, 1, 7, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    expect_out("basic.r8", 0, 0, 0, 0, 1, 8, 1, 0);
    tick();
    expect_out("basic.r9", 0, 0, 0, 0, 1, 9, 1, 0);
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("basic.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Empty request
    request(20, 2, 20, 1);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("empty.ack", 1, 1, 1, 20, 0, 0, 1, 0);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("empty.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Wrap-around with stalls: 254,255,0,1
    request(2, 250, 254, 2);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("wrap.ack", 1, 2, 0, 2, 0, 0, 1, 0);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("wrap.r254", 0, 0, 0, 0, 1, 254, 1, 0);
    tick();
    expect_out("wrap.stall254", 0, 0, 0, 0, 1, 254, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("wrap.r255", 0, 0, 0, 0, 1, 255, 1, 0);
    tick();
    expect_out("wrap.stall255", 0, 0, 0, 0, 1, 255, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    expect_out("wrap.r0", 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("wrap.r1", 0, 0, 0, 0, 1, 1, 1, 0);
    tick();
    expect_out("wrap.stall1", 0, 0, 0, 0, 1, 1, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("wrap.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Invalid eseq: cnt=7 exceeds window 5
    request(10, 5, 3, 4);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("inval.ack", 1, 4, 1, 10, 0, 0, 1, 1);
    tick();
    expect_out("inval.ackwait", 1, 4, 1, 10, 0, 0, 1, 0);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("inval.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // Mid-replay re-request restarts at 8
    request(10, 2, 7, 2);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("rereq.r7", 0, 0, 0, 0, 1, 7, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("rereq.r8", 0, 0, 0, 0, 1, 8, 1, 0);
    request(10, 2, 8, 4);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("rereq.ack", 1, 4, 0, 10, 0, 0, 1, 0);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("rereq.r8b", 0, 0, 0, 0, 1, 8, 1, 0);
    bus.packer_replay_ready = 1'b1;
    tick();
    expect_out("rereq.r9", 0, 0, 0, 0, 1, 9, 1, 0);
    tick();
    bus.packer_replay_ready = 1'b0;
    expect_out("rereq.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // New request in the same cycle as ack_ready: latest wins, stays in LLRACK
    request(10, 2, 7, 2);
    tick();
    expect_out("same.ack1", 1, 2, 0, 10, 0, 0, 1, 0);
    request(10, 2, 10, 6);
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("same.ack2", 1, 6, 1, 10, 0, 0, 1, 0);
    tick();
    bus.packer_ack_ready = 1'b0;
    expect_out("same.done", 0, 0, 0, 0, 0, 0, 0, 0);

    // phy_reinit in LLRACK drops a simultaneous request
    request(10, 2, 7, 3);
    tick();
    expect_out("reinit.ack", 1, 3, 0, 10, 0, 0, 1, 0);
    request(10, 2, 5, 7);
    bus.phy_reinit = 1'b1;
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    expect_out("reinit.held", 0, 0, 0, 0, 0, 0, 0, 0);
    bus.phy_reinit = 1'b0;
    tick();
    expect_out("reinit.after", 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef RRSM_REPLAY_STATS_EN
    $display("[%0t] stats: acks=%0d flits=%0d", $time, ack_count, flit_count);
    chk("stats.acks", 32'(ack_count), 32'd8);
    chk("stats.flits", 32'(flit_count), 32'd10);
`endif

    // Reset in the middle of a replay
    request(10, 2, 7, 3);
    tick();
    bus.unpacker_retry_req_valid = 1'b0;
    bus.packer_ack_ready = 1'b1;
    tick();
    bus.packer_ack_ready = 1'b0;
    bus.packer_replay_ready = 1'b1;
    tick();
    expect_out("rstmid.r8", 0, 0, 0, 0, 1, 8, 1, 0);
    srst = 1'b1;
    tick();
    expect_out("rstmid.reset", 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef RRSM_REPLAY_STATS_EN
    chk("rstmid.acks", 32'(ack_count), 32'd0);
    chk("rstmid.flits", 32'(flit_count), 32'd0);
`endif
    srst = 1'b0;
    idle_inputs();
    tick();
    expect_out("rstmid.idle", 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
